// File: rtl/chdr_fxp_narrow.sv
// CHDR sample-width reducer: gain shift, round, saturate and pack 16-bit lanes into OUT_W-bit lanes.
// Define CHDR_FXP_NARROW_CLIP_CNT_EN to turn debug into a saturation-event counter.
module chdr_fxp_narrow #(
   parameter int unsigned BASE  = 0,
   parameter int unsigned RATIO = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [63:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   output logic [31:0] debug
);

   localparam int unsigned OUT_W = 16 / RATIO;
   localparam int unsigned FLD_W = 64 / RATIO;
   localparam int unsigned RSH   = (RATIO == 4) ? 2 : 1;
   localparam int          RND   = 1 << (15 - OUT_W);
   localparam int          QMAX  = (1 << (OUT_W - 1)) - 1;
   localparam logic [OUT_W-1:0] QPOS = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic [OUT_W-1:0] QNEG = {1'b1, {(OUT_W - 1){1'b0}}};

   if (RATIO != 2 && RATIO != 4) begin : g_bad_ratio
      $error("chdr_fxp_narrow: RATIO must be 2 or 4");
   end

   typedef enum logic [1:0] {StHeader = 2'd0, StTime = 2'd1, StPack = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [63:0] pack_q, pack_d;
   logic [3:0]  snap_q, snap_d;
   logic [63:0] o_tdata_q, o_tdata_d;
   logic        o_tlast_q, o_tlast_d;
   logic        o_tvalid_q, o_tvalid_d;
   logic [16:0] sid_q;
   logic [3:0]  shift_q;

   logic        can_out, accept;
   logic        wr_sid, wr_shift;
   logic [15:0] hdr_h, hdr_len;
   logic [31:0] hdr_lo;
   logic [63:0] merged;
   logic        unused_set_data;

   logic signed [23:0]      ext      [4];
   logic signed [15:0]      sat16    [4];
   logic signed [16:0]      rnd      [4];
   logic signed [16:0]      quo      [4];
   logic signed [OUT_W-1:0] narrowed [4];
   logic [FLD_W-1:0]        line_bits;

   assign unused_set_data = ^set_data[31:17];
   assign wr_sid   = set_stb && (set_addr == 8'(BASE));
   assign wr_shift = set_stb && (set_addr == 8'(BASE + 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sid_q   <= '0;
         shift_q <= '0;
      end else begin
         if (wr_sid) sid_q <= set_data[16:0];
         if (wr_shift) shift_q <= (set_data[3:0] > 4'd8) ? 4'd8 : set_data[3:0];
      end
   end

   // Per-lane shift, saturate to 16 bits, round-half-up, arithmetic shift, saturate to OUT_W.
   always_comb begin
      line_bits = '0;
      for (int i = 0; i < 4; i++) begin
         ext[i] = {{8{i_tdata[63-16*i]}}, i_tdata[63-16*i -: 16]} << snap_q;
         if (ext[i] > 24'sd32767) begin
            sat16[i] = 16'sh7fff;
         end else if (ext[i] < -24'sd32768) begin
            sat16[i] = 16'sh8000;
         end else begin
            sat16[i] = ext[i][15:0];
         end
         rnd[i] = {sat16[i][15], sat16[i]} + 17'(RND);
         quo[i] = rnd[i] >>> (16 - OUT_W);
         if (quo[i] > 17'(QMAX)) begin
            narrowed[i] = QPOS;
         end else if (quo[i] < -17'(QMAX) - 17'sd1) begin
            narrowed[i] = QNEG;
         end else begin
            narrowed[i] = quo[i][OUT_W-1:0];
         end
         line_bits[FLD_W-1-OUT_W*i -: OUT_W] = narrowed[i];
      end
   end

   assign merged   = pack_q | ({line_bits, {(64 - FLD_W){1'b0}}} >> (FLD_W * lane_q));
   assign can_out  = !o_tvalid_q || o_tready;
   assign i_tready = can_out;
   assign accept   = i_tvalid && can_out;

   assign hdr_h   = i_tdata[61] ? 16'd16 : 16'd8;
   assign hdr_len = hdr_h + ((i_tdata[47:32] - hdr_h) >> RSH);
   assign hdr_lo  = sid_q[16] ? {i_tdata[15:0], sid_q[15:0]} : i_tdata[31:0];

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      snap_d     = snap_q;
      o_tdata_d  = o_tdata_q;
      o_tlast_d  = o_tlast_q;
      o_tvalid_d = o_tvalid_q && !o_tready;
      if (accept) begin
         case (state_q)
            StHeader: begin
               o_tvalid_d = 1'b1;
               o_tdata_d  = {i_tdata[63:48], hdr_len, hdr_lo};
               o_tlast_d  = i_tlast;
               snap_d     = shift_q;
               lane_d     = '0;
               pack_d     = '0;
               if (i_tlast)          state_d = StHeader;
               else if (i_tdata[61]) state_d = StTime;
               else                  state_d = StPack;
            end
            StTime: begin
               o_tvalid_d = 1'b1;
               o_tdata_d  = i_tdata;
               o_tlast_d  = i_tlast;
               state_d    = i_tlast ? StHeader : StPack;
            end
            StPack: begin
               if (i_tlast || lane_q == 2'(RATIO - 1)) begin
                  o_tvalid_d = 1'b1;
                  o_tdata_d  = merged;
                  o_tlast_d  = i_tlast;
                  pack_d     = '0;
                  lane_d     = '0;
                  state_d    = i_tlast ? StHeader : StPack;
               end else begin
                  pack_d = merged;
                  lane_d = lane_q + 2'd1;
               end
            end
            default: state_d = StHeader;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHeader;
         lane_q     <= '0;
         pack_q     <= '0;
         snap_q     <= '0;
         o_tdata_q  <= '0;
         o_tlast_q  <= 1'b0;
         o_tvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         snap_q     <= snap_d;
         o_tdata_q  <= o_tdata_d;
         o_tlast_q  <= o_tlast_d;
         o_tvalid_q <= o_tvalid_d;
      end
   end

   assign o_tdata  = o_tdata_q;
   assign o_tlast  = o_tlast_q;
   assign o_tvalid = o_tvalid_q;

`ifdef CHDR_FXP_NARROW_CLIP_CNT_EN
   logic [3:0]  clip;
   logic [31:0] clip_cnt_q;

   // A lane clipped if either saturation stage changed its value.
   always_comb begin
      clip = '0;
      for (int i = 0; i < 4; i++) begin
         clip[i] = (ext[i] != 24'(sat16[i])) || (quo[i] != 17'(narrowed[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst || wr_shift) begin
         clip_cnt_q <= '0;
      end else if (accept && state_q == StPack) begin
         clip_cnt_q <= clip_cnt_q + 32'(clip[0]) + 32'(clip[1]) + 32'(clip[2]) + 32'(clip[3]);
      end
   end

   assign debug = clip_cnt_q;
`else
   assign debug = {30'b0, state_q};
`endif

endmodule
